mem_arbiter: RTL and testbench

Shares the single byte-wide RAM port between instruction fetch and the load/store buffer (LSB). Serialises multi-byte accesses into per-byte RAM cycles and assembles or splits little-endian words. Returns completion pulses to each requester and handles mispredict flush and the I/O-buffer-full stall. Sits between the LSB and fetch unit on one side and the external RAM/IO bus on the other.

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and the load/store buffer onto one byte-wide synchronous RAM port,
// serialising 1/2/4-byte little-endian accesses into per-byte RAM cycles.
module mem_arbiter #(
  parameter int         ROB_W = 4,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jump_wrong,
  input  logic             io_buffer_full,
  input  logic             if_req_flag,
  input  logic [31:0]      if_req_addr,
  output logic             if_done_flag,
  output logic [31:0]      if_done_inst,
  input  logic             lsb_req_flag,
  input  logic             lsb_req_type,
  input  logic [1:0]       lsb_req_width,
  input  logic [31:0]      lsb_req_addr,
  input  logic [31:0]      lsb_req_data,
  input  logic [ROB_W-1:0] lsb_req_rob_id,
  output logic             lsb_done_flag,
  output logic [31:0]      lsb_done_data,
  output logic [ROB_W-1:0] lsb_done_rob_id,
  input  logic [7:0]       mem_din,
  output logic [7:0]       mem_dout,
  output logic [31:0]      mem_a,
  output logic             mem_wr
);
  // state  | meaning
  // IDLE   | waiting to accept a request (LSB has priority)
  // LSB_RD | LSB load, one byte address per cycle
  // LSB_WR | LSB store, one byte write per cycle
  // IF_RD  | instruction fetch, always 4 bytes
  // DONE   | one-cycle turnaround, requests ignored
  typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IF_RD, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d, n_q, n_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ROB_W-1:0] tag_q, tag_d;
  logic [31:0]      mem_a_q, mem_a_d;
  logic [7:0]       mem_dout_q, mem_dout_d;
  logic             mem_wr_q, mem_wr_d;
  logic             if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [31:0]      if_inst_q, if_inst_d, lsb_data_q, lsb_data_d;
  logic [ROB_W-1:0] lsb_tag_q, lsb_tag_d;

  logic [2:0]  cnt_nx, req_n;
  logic [1:0]  cap_idx;
  logic [31:0] rd_merge;
  logic        io_stall;

  // The byte on mem_din belongs to the address issued two edges earlier, hence cnt-1.
  assign cnt_nx   = cnt_q + 3'd1;
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign rd_merge = rdata_q | ({24'd0, mem_din} << {cap_idx, 3'b000});
  assign io_stall = io_buffer_full && (addr_q[17:16] == IO_HI);
  assign req_n    = (lsb_req_width == 2'b00) ? 3'd1 : (lsb_req_width == 2'b01) ? 3'd2 : 3'd4;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tag_d      = tag_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    if_inst_d  = if_inst_q;
    lsb_data_d = lsb_data_q;
    lsb_tag_d  = lsb_tag_q;
    case (state_q)
      IDLE: begin
        if (lsb_req_flag) begin
          addr_d  = lsb_req_addr;
          wdata_d = lsb_req_data;
          tag_d   = lsb_req_rob_id;
          n_d     = req_n;
          cnt_d   = 3'd0;
          rdata_d = 32'd0;
          mem_a_d = lsb_req_addr;
          if (lsb_req_type) begin
            state_d    = LSB_WR;
            mem_dout_d = lsb_req_data[7:0];
            mem_wr_d   = !(io_buffer_full && (lsb_req_addr[17:16] == IO_HI));
          end else begin
            state_d = LSB_RD;
          end
        end else if (if_req_flag && !jump_wrong) begin
          state_d = IF_RD;
          addr_d  = if_req_addr;
          n_d     = 3'd4;
          cnt_d   = 3'd0;
          rdata_d = 32'd0;
          mem_a_d = if_req_addr;
        end
      end
      LSB_RD, IF_RD: begin
        if (state_q == IF_RD && jump_wrong) begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx < n_q) mem_a_d = addr_q + 32'(cnt_nx);
          if (cnt_q != 3'd0) rdata_d = rd_merge;
          if (cnt_q == n_q) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = rd_merge;
            end else begin
              lsb_done_d = 1'b1;
              lsb_data_d = rd_merge;
              lsb_tag_d  = tag_q;
            end
          end
        end
      end
      LSB_WR: begin
        if (mem_wr_q) begin
          if (cnt_nx == n_q) begin
            state_d    = DONE;
            cnt_d      = 3'd0;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
            lsb_data_d = 32'd0;
            lsb_tag_d  = tag_q;
          end else begin
            cnt_d      = cnt_nx;
            mem_a_d    = addr_q + 32'(cnt_nx);
            mem_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
            mem_wr_d   = !io_stall;
          end
        end else begin
          mem_wr_d = !io_stall;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      tag_q      <= '0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      lsb_done_q <= 1'b0;
      lsb_data_q <= 32'd0;
      lsb_tag_q  <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tag_q      <= tag_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      lsb_done_q <= lsb_done_d;
      lsb_data_q <= lsb_data_d;
      lsb_tag_q  <= lsb_tag_d;
    end
  end

  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign mem_wr          = mem_wr_q;
  assign if_done_flag    = if_done_q;
  assign if_done_inst    = if_inst_q;
  assign lsb_done_flag   = lsb_done_q;
  assign lsb_done_data   = lsb_data_q;
  assign lsb_done_rob_id = lsb_tag_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and
// randomized traffic against a byte-array memory model.
module tb_mem_arbiter;
  localparam int ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             jump_wrong = 1'b0;
  logic             io_buffer_full = 1'b0;
  logic             if_req_flag = 1'b0;
  logic [31:0]      if_req_addr = 32'd0;
  logic             if_done_flag;
  logic [31:0]      if_done_inst;
  logic             lsb_req_flag = 1'b0;
  logic             lsb_req_type = 1'b0;
  logic [1:0]       lsb_req_width = 2'b00;
  logic [31:0]      lsb_req_addr = 32'd0;
  logic [31:0]      lsb_req_data = 32'd0;
  logic [ROB_W-1:0] lsb_req_rob_id = '0;
  logic             lsb_done_flag;
  logic [31:0]      lsb_done_data;
  logic [ROB_W-1:0] lsb_done_rob_id;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;

  mem_arbiter #(.ROB_W(ROB_W), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong), .io_buffer_full(io_buffer_full),
    .if_req_flag(if_req_flag), .if_req_addr(if_req_addr),
    .if_done_flag(if_done_flag), .if_done_inst(if_done_inst),
    .lsb_req_flag(lsb_req_flag), .lsb_req_type(lsb_req_type), .lsb_req_width(lsb_req_width),
    .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data), .lsb_req_rob_id(lsb_req_rob_id),
    .lsb_done_flag(lsb_done_flag), .lsb_done_data(lsb_done_data), .lsb_done_rob_id(lsb_done_rob_id),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        typ;
    logic [1:0]  wid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    logic        jw;
    int          stall;
    int          rdy_at;
    int          rdy_len;
    logic [31:0] exp_d;
    int          exp_lat;
    int          exp_nwr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] pre     [logic [31:0]];
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int         wr_cnt = 0;
  logic [31:0] tr_a[$];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    if (pre.exists(a)) return pre[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (pre.exists(a)) return pre[a];
    return dflt(a);
  endfunction

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < nbytes(w); k++) r[8*k +: 8] = ref_rd(a + 32'(k));
    return r;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int k = 0; k < nbytes(w); k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
  endfunction

  // Synchronous RAM that, like the rest of the system, pauses while rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        wr_cnt++;
      end
      mem_din <= ram_rd(mem_a);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge; latency counts rising edges after acceptance edge e0.
  task automatic run_lsb(input vec_t v, input bit hold, output logic [31:0] d,
                         output logic [ROB_W-1:0] t, output int lat, output int nwr);
    int w0;
    w0 = wr_cnt;
    tr_a.delete();
    lsb_req_flag = 1'b1; lsb_req_type = v.typ; lsb_req_width = v.wid;
    lsb_req_addr = v.addr; lsb_req_data = v.data; lsb_req_rob_id = v.tag;
    jump_wrong = v.jw; io_buffer_full = (v.stall > 0);
    lat = -1; d = 32'd0; t = '0;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      @(posedge clk); @(negedge clk);
      tr_a.push_back(mem_a);
      if (lsb_done_flag) begin lat = j; d = lsb_done_data; t = lsb_done_rob_id; end
      io_buffer_full = (j + 1 < v.stall);
      rdy = !(v.rdy_len > 0 && j >= v.rdy_at && j < v.rdy_at + v.rdy_len);
    end
    if (!hold) lsb_req_flag = 1'b0;
    jump_wrong = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    nwr = wr_cnt - w0;
    @(posedge clk); @(negedge clk);
    chk("lsb_done_one_cycle", 32'(lsb_done_flag), 32'd0);
    lsb_req_flag = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] a, output logic [31:0] inst, output int lat);
    if_req_flag = 1'b1; if_req_addr = a;
    lat = -1; inst = 32'd0;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      @(posedge clk); @(negedge clk);
      if (if_done_flag) begin lat = j; inst = if_done_inst; end
    end
    if_req_flag = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("if_done_one_cycle", 32'(if_done_flag), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[15];
    vec_t        v;
    logic [31:0] d, inst, a4, ldat;
    logic [ROB_W-1:0] t;
    int          lat, nwr, ld, fd, seen, exp_lat;
    logic [31:0] exp_d;

    pre[32'h100] = 8'h11; pre[32'h101] = 8'h22; pre[32'h102] = 8'h33; pre[32'h103] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      pre[32'h200 + 32'(k)] = 8'h77;
      pre[32'h300 + 32'(k)] = 8'h00;
    end
    pre[32'h400] = 8'hA1; pre[32'h401] = 8'hB2; pre[32'h402] = 8'hC3; pre[32'h403] = 8'hD4;
    pre[32'h500] = 8'h01; pre[32'h501] = 8'h23; pre[32'h502] = 8'h45; pre[32'h503] = 8'h67;

    //            typ   wid    addr          data          tag   jw    st ra rl exp_d         lat nwr
    tbl[0]  = '{1'b0, 2'b10, 32'h100,      32'h0,        4'h3, 1'b0, 0, 0, 0, 32'h44332211, 5, 0};
    tbl[1]  = '{1'b1, 2'b01, 32'h200,      32'hAABBCCDD, 4'h5, 1'b0, 0, 0, 0, 32'h0,        2, 2};
    tbl[2]  = '{1'b0, 2'b10, 32'h200,      32'h0,        4'h6, 1'b0, 0, 0, 0, 32'h7777CCDD, 5, 0};
    tbl[3]  = '{1'b0, 2'b01, 32'h201,      32'h0,        4'h7, 1'b0, 0, 0, 0, 32'h000077CC, 3, 0};
    tbl[4]  = '{1'b0, 2'b00, 32'h203,      32'h0,        4'h8, 1'b1, 0, 0, 0, 32'h00000077, 2, 0};
    tbl[5]  = '{1'b1, 2'b10, 32'hFFFFFFFE, 32'h04030201, 4'h9, 1'b0, 0, 0, 0, 32'h0,        4, 4};
    tbl[6]  = '{1'b0, 2'b11, 32'hFFFFFFFE, 32'h0,        4'hA, 1'b0, 0, 0, 0, 32'h04030201, 5, 0};
    tbl[7]  = '{1'b0, 2'b01, 32'h0,        32'h0,        4'hB, 1'b0, 0, 0, 0, 32'h00000403, 3, 0};
    tbl[8]  = '{1'b1, 2'b00, 32'h300,      32'h123456EF, 4'hC, 1'b0, 2, 0, 0, 32'h0,        1, 1};
    tbl[9]  = '{1'b0, 2'b10, 32'h300,      32'h0,        4'hD, 1'b0, 0, 1, 2, 32'h000000EF, 7, 0};
    tbl[10] = '{1'b1, 2'b00, 32'h30000,    32'h0000005A, 4'hE, 1'b0, 3, 0, 0, 32'h0,        4, 1};
    tbl[11] = '{1'b1, 2'b10, 32'h30010,    32'hDEADBEEF, 4'hF, 1'b1, 2, 0, 0, 32'h0,        6, 4};
    tbl[12] = '{1'b0, 2'b10, 32'h30010,    32'h0,        4'h1, 1'b0, 0, 0, 0, 32'hDEADBEEF, 5, 0};
    tbl[13] = '{1'b1, 2'b00, 32'h20000,    32'h00000099, 4'h2, 1'b0, 3, 0, 0, 32'h0,        1, 1};
    tbl[14] = '{1'b0, 2'b00, 32'h20000,    32'h0,        4'h0, 1'b0, 0, 0, 0, 32'h00000099, 2, 0};

    // Reset values (asynchronous assertion before any clock edge).
    #1 rst = 1'b0;
    #2;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_done_flags", {30'd0, lsb_done_flag, if_done_flag}, 32'd0);
    chk("rst_lsb_data", lsb_done_data, 32'd0);
    chk("rst_lsb_tag", 32'(lsb_done_rob_id), 32'd0);
    chk("rst_if_inst", if_done_inst, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Word load: address walk e0..e3 and the stale-request guard in DONE.
    run_lsb(tbl[0], 1'b1, d, t, lat, nwr);
    chk("b_data", d, 32'h44332211);
    chk("b_tag", 32'(t), 32'h3);
    chk("b_lat", 32'(lat), 32'd5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b_mem_a_e%0d", k), (tr_a.size() > k) ? tr_a[k] : 32'hDEAD0000, 32'h100 + 32'(k));
    chk("b_stale_mem_a", mem_a, 32'h103);
    seen = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (lsb_done_flag) seen++;
    end
    chk("b_stale_done", 32'(seen), 32'd0);

    foreach (tbl[i]) begin
      run_lsb(tbl[i], 1'b0, d, t, lat, nwr);
      chk($sformatf("vec%0d_data", i), d, tbl[i].exp_d);
      chk($sformatf("vec%0d_tag", i), 32'(t), 32'(tbl[i].tag));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(tbl[i].exp_nwr));
      if (tbl[i].typ) ref_store(tbl[i].addr, tbl[i].wid, tbl[i].data);
    end

    // Simultaneous requests: LSB first, fetch accepted at e_d+2.
    lsb_req_flag = 1'b1; lsb_req_type = 1'b0; lsb_req_width = 2'b00;
    lsb_req_addr = 32'h100; lsb_req_rob_id = 4'h4;
    if_req_flag = 1'b1; if_req_addr = 32'h400;
    ld = -1; fd = -1; a4 = 32'd0; ldat = 32'd0; inst = 32'd0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); @(negedge clk);
      if (j == 4) a4 = mem_a;
      if (lsb_done_flag && ld < 0) begin ld = j; ldat = lsb_done_data; lsb_req_flag = 1'b0; end
      if (if_done_flag && fd < 0) begin fd = j; inst = if_done_inst; if_req_flag = 1'b0; end
    end
    lsb_req_flag = 1'b0; if_req_flag = 1'b0;
    chk("d_lsb_lat", 32'(ld), 32'd2);
    chk("d_lsb_data", ldat, 32'h11);
    chk("d_if_mem_a", a4, 32'h400);
    chk("d_if_lat", 32'(fd), 32'd9);
    chk("d_if_inst", inst, 32'hD4C3B2A1);

    // Fetch aborted by jump_wrong at e2, then a new fetch after it falls.
    if_req_flag = 1'b1; if_req_addr = 32'h400;
    fd = -1; a4 = 32'd0; seen = 0; inst = 32'd0;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk); @(negedge clk);
      if (mem_wr) seen++;
      if (j == 1) begin jump_wrong = 1'b1; if_req_addr = 32'h500; end
      if (j == 2) jump_wrong = 1'b0;
      if (j == 3) a4 = mem_a;
      if (if_done_flag && fd < 0) begin fd = j; inst = if_done_inst; if_req_flag = 1'b0; end
    end
    if_req_flag = 1'b0; jump_wrong = 1'b0;
    chk("e_refetch_lat", 32'(fd), 32'd8);
    chk("e_refetch_inst", inst, 32'h67452301);
    chk("e_refetch_mem_a", a4, 32'h500);
    chk("e_no_write", 32'(seen), 32'd0);

    // Randomized traffic against the memory model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        v.addr = 32'h1000 + 32'($urandom_range(0, 63));
        run_if(v.addr, inst, lat);
        chk($sformatf("rnd%0d_if_inst", it), inst, ref_load(v.addr, 2'b10));
        chk($sformatf("rnd%0d_if_lat", it), 32'(lat), 32'd5);
      end else begin
        v.typ     = 1'($urandom_range(0, 1));
        v.wid     = 2'($urandom_range(0, 3));
        v.addr    = ($urandom_range(0, 3) == 0) ? 32'h30040 + 32'($urandom_range(0, 63))
                                                : 32'h1000 + 32'($urandom_range(0, 63));
        v.data    = $urandom;
        v.tag     = 4'($urandom_range(0, 15));
        v.jw      = 1'($urandom_range(0, 1));
        v.stall   = int'($urandom_range(0, 3));
        v.rdy_at  = 0;
        v.rdy_len = 0;
        if (v.typ) begin
          exp_d   = 32'd0;
          exp_lat = nbytes(v.wid) + ((v.addr[17:16] == 2'b11) ? v.stall : 0);
        end else begin
          exp_d   = ref_load(v.addr, v.wid);
          exp_lat = nbytes(v.wid) + 1;
        end
        run_lsb(v, 1'b0, d, t, lat, nwr);
        chk($sformatf("rnd%0d_data", it), d, exp_d);
        chk($sformatf("rnd%0d_tag", it), 32'(t), 32'(v.tag));
        chk($sformatf("rnd%0d_lat", it), 32'(lat), 32'(exp_lat));
        if (v.typ) ref_store(v.addr, v.wid, v.data);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset asserted in the middle of a word store.
    lsb_req_flag = 1'b1; lsb_req_type = 1'b1; lsb_req_width = 2'b10;
    lsb_req_addr = 32'h600; lsb_req_data = 32'h11223344; lsb_req_rob_id = 4'h7;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("f_mem_a_e1", mem_a, 32'h601);
    chk("f_mem_wr_e1", 32'(mem_wr), 32'd1);
    #2 rst = 1'b0; lsb_req_flag = 1'b0;
    #1;
    chk("f_rst_mem_a", mem_a, 32'd0);
    chk("f_rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("f_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("f_rst_lsb_data", lsb_done_data, 32'd0);
    chk("f_rst_lsb_tag", 32'(lsb_done_rob_id), 32'd0);
    chk("f_rst_if_inst", if_done_inst, 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (lsb_done_flag || mem_wr) seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (lsb_done_flag) seen++;
    end
    chk("f_no_done", 32'(seen), 32'd0);
    run_if(32'h400, inst, lat);
    chk("f_post_rst_inst", inst, 32'hD4C3B2A1);
    chk("f_post_rst_lat", 32'(lat), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
